// File: rtl/uart_tx_feeder_if.sv
// Bundled write-side, drain-control and transmitter-side signals of uart_tx_feeder.
// The master drives bytes and controls; the slave (the feeder) drives the TX request and status.
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_en;
    logic          tx_en;
    logic          ovf_clr;
    logic [7:0]    tdata;
    logic          tdata_req;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;

    modport master (
        output wr_data, wr_en, tx_en, ovf_clr,
        input  tdata, tdata_req, full, empty, count, overflow, busy
    );

    modport slave (
        input  wr_data, wr_en, tx_en, ovf_clr,
        output tdata, tdata_req, full, empty, count, overflow, busy
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus pacing FSM feeding a UART transmitter that has no busy output.
// Each one-cycle request is followed by GAP_CYCLES idle cycles so no frame is overrun.
module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 1100
) (
    input logic        clk,
    input logic        rstn,
    uart_tx_feeder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    state_t        state_q;
    state_t        state_d;
    logic [15:0]   gap_q;
    logic [15:0]   gap_d;
    logic [7:0]    tdata_q;
    logic [7:0]    tdata_d;
    logic          req_q;
    logic          req_d;

    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A full FIFO still accepts a write when the drain frees a slot on the same edge.
    assign push  = bus.wr_en && (!full || pop);
    assign drop  = bus.wr_en && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop)             overflow_q <= 1'b1;
            else if (bus.ovf_clr) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gap_q   <= '0;
            tdata_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            tdata_q <= tdata_d;
            req_q   <= req_d;
        end
    end

    // tx_en is only consulted in IDLE, so a started gap always runs to completion.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        tdata_d = tdata_q;
        req_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_en && !empty) begin
                    tdata_d = mem[rd_ptr];
                    req_d   = 1'b1;
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                gap_d   = 16'(GAP_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tdata     = tdata_q;
    assign bus.tdata_req = req_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
